// File: rtl/seq_mult_sx.sv
// Sequential shift-add multiplier (signed or unsigned) with valid/ready handshakes
// and optional output scaling: arithmetic shift, round-half-up, saturation.
module seq_mult_sx #(
    parameter int unsigned A_W    = 8,
    parameter int unsigned B_W    = 9,
    parameter int unsigned SIGNED = 1,
    parameter int unsigned SHIFT  = 0,
    parameter int unsigned ROUND  = 0,
    parameter int unsigned SAT    = 0,
    parameter int unsigned OUT_W  = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned P_W    = A_W + B_W;
    // Scaling width: one guard bit above the product, and wide enough for the range check.
    localparam int unsigned E_W    = ((P_W + 1) > (OUT_W + 1)) ? (P_W + 1) : (OUT_W + 1);
    localparam int unsigned C_W    = (A_W > 1) ? $clog2(A_W) : 1;
    localparam int unsigned RND_SH = (SHIFT > 0) ? (SHIFT - 1) : 0;
    localparam logic [E_W-1:0] RND = ((ROUND != 0) && (SHIFT > 0)) ? (E_W'(1) << RND_SH) : '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [C_W-1:0]     count_q, count_d;
    logic [P_W-1:0]     acc_q, acc_d;
    logic [P_W-1:0]     mcand_q, mcand_d;
    logic [A_W-1:0]     a_q, a_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;

    logic               last;
    logic               b_sx;
    logic [P_W-1:0]     b_ext;
    logic [P_W-1:0]     addend;
    logic [P_W-1:0]     acc_nxt;

    logic               p_sx;
    logic [E_W-1:0]     r;
    logic signed [E_W-1:0] r_s;
    logic [E_W-1:0]     s_arith;
    logic [E_W-1:0]     s_log;
    logic [E_W-1:0]     s;
    logic [E_W-OUT_W:0] s_top;
    logic               ovf_sc;
    logic [OUT_W-1:0]   sat_val;
    logic [OUT_W-1:0]   out_sc;

    assign last = (count_q == C_W'(A_W - 1));

    // Extend the multiplicand to the full product width.
    always_comb begin
        b_sx  = (SIGNED != 0) && b[B_W-1];
        b_ext = {{A_W{b_sx}}, b};
    end

    // One partial-product step; the signed MSB of a carries negative weight.
    always_comb begin
        addend = a_q[count_q] ? mcand_q : '0;
        if ((SIGNED != 0) && last) begin
            acc_nxt = acc_q - addend;
        end else begin
            acc_nxt = acc_q + addend;
        end
    end

    // Round, shift, range-check and optionally saturate the final product.
    always_comb begin
        p_sx    = (SIGNED != 0) && acc_nxt[P_W-1];
        r       = {{(E_W - P_W){p_sx}}, acc_nxt} + RND;
        r_s     = r;
        s_arith = r_s >>> SHIFT;
        s_log   = r >> SHIFT;
        s       = (SIGNED != 0) ? s_arith : s_log;
        s_top   = s[E_W-1:OUT_W-1];
        if (SIGNED != 0) begin
            ovf_sc  = !((&s_top) || !(|s_top));
            sat_val = s[E_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            ovf_sc  = |s_top[E_W-OUT_W:1];
            sat_val = {OUT_W{1'b1}};
        end
        out_sc = ((SAT != 0) && ovf_sc) ? sat_val : s[OUT_W-1:0];
    end

    // Next-state and register-input logic.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        a_d         = a_q;
        out_d       = out_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    mcand_d = b_ext;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = ST_MULT;
                end
            end
            ST_MULT: begin
                acc_d   = acc_nxt;
                mcand_d = mcand_q << 1;
                count_d = count_q + C_W'(1);
                if (last) begin
                    out_d       = out_sc;
                    ovf_d       = ovf_sc;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            a_q         <= '0;
            out_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            a_q         <= a_d;
            out_q       <= out_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign ovf       = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seq_mult_sx.sv
// Bench for seq_mult_sx: four parameterisations driven in lockstep, checked
// against an integer-arithmetic reference model.
module tb_seq_mult_sx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [8:0] b;

    logic        ir0, ir1, ir2, ir3;
    logic        ov0, ov1, ov2, ov3;
    logic        of0, of1, of2, of3;
    logic        bz0, bz1, bz2, bz3;
    logic [16:0] o0, o1;
    logic [7:0]  o2, o3;

    int checks = 0;
    int passes = 0;

    logic [7:0]  cur_a;
    logic [8:0]  cur_b;
    logic [16:0] save_o0;
    logic [7:0]  save_o2;

    always #5 clk = ~clk;

    seq_mult_sx u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .a(a), .b(b),
        .out_valid(ov0), .out_ready(out_ready), .out(o0), .ovf(of0), .busy(bz0)
    );
    seq_mult_sx #(.SIGNED(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b),
        .out_valid(ov1), .out_ready(out_ready), .out(o1), .ovf(of1), .busy(bz1)
    );
    seq_mult_sx #(.OUT_W(8), .SHIFT(8), .ROUND(1), .SAT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .a(a), .b(b),
        .out_valid(ov2), .out_ready(out_ready), .out(o2), .ovf(of2), .busy(bz2)
    );
    seq_mult_sx #(.OUT_W(8), .SHIFT(8), .ROUND(1), .SAT(0)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir3), .a(a), .b(b),
        .out_valid(ov3), .out_ready(out_ready), .out(o3), .ovf(of3), .busy(bz3)
    );

    // Reference: exact product, then round/shift/range/saturate on integers.
    function automatic logic [31:0] mdl(input logic [7:0] av, input logic [8:0] bv,
                                        input int sgn, input int sh, input int rnd,
                                        input int sat, input int ow, output logic v);
        longint x, y, p, q, lo, hi, res;
        if (sgn != 0) begin
            x = $signed(av);
            y = $signed(bv);
            lo = -(longint'(1) << (ow - 1));
            hi = (longint'(1) << (ow - 1)) - 1;
        end else begin
            x = longint'(av);
            y = longint'(bv);
            lo = 0;
            hi = (longint'(1) << ow) - 1;
        end
        p = x * y;
        if (rnd != 0 && sh > 0) p = p + (longint'(1) << (sh - 1));
        q = p >>> sh;
        v = (q < lo) || (q > hi);
        if (sat != 0 && v) res = (q > hi) ? hi : lo;
        else res = q;
        res = res & ((longint'(1) << ow) - 1);
        return 32'(res);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic start_op(input logic [7:0] av, input logic [8:0] bv);
        @(negedge clk);
        chk("in_ready_idle", 32'(ir0), 32'd1);
        in_valid = 1'b1;
        a = av;
        b = bv;
        cur_a = av;
        cur_b = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 9'($urandom);
        chk("busy_accept", 32'(bz0), 32'd1);
    endtask

    task automatic wait_result();
        int cyc = 0;
        logic v;
        logic [31:0] e;
        while (ov0 !== 1'b1 && cyc < 20) begin
            chk("in_ready_mult", 32'(ir0), 32'd0);
            chk("busy_mult", 32'(bz0), 32'd1);
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'd8);
        chk("valid_all", {28'd0, ov0, ov1, ov2, ov3}, 32'hF);
        chk("in_ready_done", 32'(ir0), 32'd0);
        e = mdl(cur_a, cur_b, 1, 0, 0, 0, 17, v);
        chk("out_signed", 32'(o0), e);
        chk("ovf_signed", 32'(of0), 32'(v));
        e = mdl(cur_a, cur_b, 0, 0, 0, 0, 17, v);
        chk("out_unsigned", 32'(o1), e);
        chk("ovf_unsigned", 32'(of1), 32'(v));
        e = mdl(cur_a, cur_b, 1, 8, 1, 1, 8, v);
        chk("out_sat", 32'(o2), e);
        chk("ovf_sat", 32'(of2), 32'(v));
        e = mdl(cur_a, cur_b, 1, 8, 1, 0, 8, v);
        chk("out_wrap", 32'(o3), e);
        chk("ovf_wrap", 32'(of3), 32'(v));
        save_o0 = o0;
        save_o2 = o2;
    endtask

    task automatic release_out(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_out", 32'(o0), 32'(save_o0));
            chk("hold_valid", 32'(ov0), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("valid_cleared", 32'(ov0), 32'd0);
        chk("in_ready_back", 32'(ir0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cur_a     = '0;
        cur_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_out", 32'(o0), 32'd0);
        chk("rst_ovf", 32'(of0), 32'd0);
        chk("rst_busy", 32'(bz0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(ir0), 32'd1);

        // -128 x 255
        start_op(8'h80, 9'h0FF);
        wait_result();
        chk("tp1_const", 32'(o0), 32'h18080);
        release_out(0);

        // 127 x -256, then 0 x -1
        start_op(8'd127, 9'h100);
        wait_result();
        chk("tp2_const", 32'(o0), 32'(17'h18100));
        release_out(1);
        start_op(8'd0, 9'h1FF);
        wait_result();
        chk("tp3_const", 32'(o0), 32'd0);
        release_out(0);

        // unsigned 255 x 511, 1 x 1
        start_op(8'd255, 9'd511);
        wait_result();
        chk("tp4_const", 32'(o1), 32'd130305);
        release_out(0);
        start_op(8'd1, 9'd1);
        wait_result();
        chk("tp5_const", 32'(o1), 32'd1);
        release_out(0);

        // scaled: 100 x 200, -128 x -256
        start_op(8'd100, 9'd200);
        wait_result();
        chk("tp6_sat", 32'(o2), 32'd78);
        chk("tp6_ovf", 32'(of2), 32'd0);
        release_out(0);
        start_op(8'h80, 9'h100);
        wait_result();
        chk("tp7_sat", 32'(o2), 32'd127);
        chk("tp7_ovf", 32'(of2), 32'd1);
        chk("tp7_wrap", 32'(o3), 32'h80);
        chk("tp7_wovf", 32'(of3), 32'd1);
        release_out(0);

        // backpressure with a second request pending
        start_op(8'd77, 9'h1A3);
        wait_result();
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'd12;
        b = 9'd34;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out", 32'(o0), 32'(save_o0));
            chk("bp_out_sat", 32'(o2), 32'(save_o2));
            chk("bp_valid", 32'(ov0), 32'd1);
            chk("bp_in_ready", 32'(ir0), 32'd0);
        end
        cur_a = 8'd12;
        cur_b = 9'd34;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_rel_valid", 32'(ov0), 32'd0);
        chk("bp_rel_ready", 32'(ir0), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accept", 32'(ir0), 32'd0);
        chk("bp_accept_busy", 32'(bz0), 32'd1);
        wait_result();
        release_out(0);

        // reset in the middle of an operation
        start_op(8'd57, 9'd33);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(ov0), 32'd0);
        chk("abort_out", 32'(o0), 32'd0);
        chk("abort_out_sat", 32'(o2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(8'd3, 9'h1FB);
        wait_result();
        chk("post_rst_const", 32'(o0), 32'(17'h1FFF1));
        release_out(0);

        // randomized operations with random backpressure
        for (int i = 0; i < 16; i++) begin
            start_op(8'($urandom), 9'($urandom));
            wait_result();
            release_out(int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seq_mult_sx.md
Name: seq_mult_sx

Overview:
- Parametrised sequential shift-add multiplier, signed or unsigned, with valid/ready handshakes on input and output.
- Optional output scaling: arithmetic right shift, round-half-up and saturation, with an overflow flag.
- Successor to the fixed 8x9 FFT-stage multiplier. Used for twiddle products in butterfly stages where a DSP block is not available or not wanted.

Parameters:
- A_W, 8: width of operand a. This is the multiplier operand; the block iterates once per bit of a.
- B_W, 9: width of operand b, the multiplicand.
- SIGNED, 1: 1 = two's-complement operands; 0 = unsigned operands.
- SHIFT, 0: right shift applied to the full product, 0..A_W+B_W-1.
- ROUND, 0: 1 = add 2^(SHIFT-1) before the shift. Ignored when SHIFT=0.
- SAT, 0: 1 = saturate the scaled result to OUT_W; 0 = wrap (keep the low OUT_W bits).
- OUT_W, 17: output width. Default is A_W+B_W.

Ports:
- clk  in  1  clock; all flops on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands are presented.
- in_ready  out  1  block can accept operands.
- a  in  A_W  multiplier operand.
- b  in  B_W  multiplicand operand.
- out_valid  out  1  result is held on out.
- out_ready  in  1  consumer accepts the result.
- out  out  OUT_W  scaled product.
- ovf  out  1  scaled result did not fit in OUT_W. Qualified by out_valid.
- busy  out  1  high in the MULT or DONE state.

Behaviour:
- Reset (async assert, sync release): state = IDLE, count = 0, accumulator = 0, out = 0, ovf = 0, out_valid = 0.
  - in_ready = 1 once rst_n is high.
  - Reset asserted mid-operation aborts the operation; no result is emitted.
- Internal product width P_W = A_W + B_W. The accumulator and the shifted multiplicand are P_W bits. b is sign-extended to P_W if SIGNED, otherwise zero-extended.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready: latch a, latch extended b, clear accumulator, count = 0, go to MULT.
  - MULT: in_ready = 0. Each cycle, if a[count] = 1, add the shifted multiplicand to the accumulator. Exception: when SIGNED and count = A_W-1, subtract instead (MSB weight is -2^(A_W-1)). Shift the multiplicand left by 1 and increment count.
    - On the cycle that processes count = A_W-1: write the scaled result to out, set ovf, set out_valid = 1, go to DONE.
  - DONE: out and ovf are held stable while out_valid & !out_ready. On out_ready: out_valid = 0, go to IDLE.
- Latency: the handshake accepted at clock edge N produces out_valid visible after edge N+A_W (8 cycles at default).
  - Minimum issue interval is A_W+2 cycles. in_ready is not asserted in DONE.
- Scaling, computed combinationally from the final accumulator value P:
  - R = P + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0), computed at P_W+1 bits.
  - Then S = R >>> SHIFT (arithmetic if SIGNED, logical otherwise).
  - ovf = 1 when S is outside the OUT_W range: signed range if SIGNED, unsigned range otherwise.
  - SAT=1 with ovf: out = max or min of that range. Otherwise out = S[OUT_W-1:0].
  - With defaults, ovf is always 0.
- Operands are sampled only on the accepting edge; changes to a and b after that are ignored.
- in_valid held high during MULT or DONE is not accepted and has no effect.
- out_ready while out_valid = 0 is ignored.

Test Plan:
- Default params, a = -128, b = 255 → out = -32640 (17'h18080) after 8 cycles, ovf = 0.
- Default params, a = 127, b = -256 → out = -32512; then a = 0, b = -1 → out = 0.
  - Also check in_ready is low for the whole operation and busy is high.
- SIGNED=0, a = 255, b = 511 → out = 130305; a = 1, b = 1 → out = 1.
- OUT_W=8, SHIFT=8, ROUND=1, SAT=1: a = 100, b = 200 → out = 78, ovf = 0.
  - a = -128, b = -256 → out = 127, ovf = 1.
  - Same case with SAT=0 → out = 8'h80, ovf = 1.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid → out is stable, in_ready stays 0, a second in_valid is not accepted. Release out_ready → next operand set is accepted two cycles later.
- Deassert rst_n at count = 3 of an operation → out_valid = 0 and out = 0 immediately. After release, a fresh multiply of 3 × -5 returns -15.
